// File: rtl/demux_1x2_buf.sv
// Buffered 1-to-2 stream demultiplexer: each accepted beat is steered by S into
// one of two independent FIFOs, so a stalled output never blocks the other.
module demux_1x2_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    input  logic             S,
    output logic [WIDTH-1:0] Y0,
    output logic             Y0_VALID,
    input  logic             Y0_READY,
    output logic [WIDTH-1:0] Y1,
    output logic             Y1_VALID,
    input  logic             Y1_READY,
    output logic [CNT_W-1:0] CNT0,
    output logic [CNT_W-1:0] CNT1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [1:0]                 fifo_full;
    logic [1:0]                 head_valid;
    logic [1:0]                 sink_ready;
    logic [1:0][WIDTH-1:0]      head_data;
    logic [1:0][CNT_W-1:0]      delivered;

    assign sink_ready = {Y1_READY, Y0_READY};

    // Ready follows only the FIFO the current beat is routed to; reset does not gate it.
    assign D_READY = S ? !fifo_full[1] : !fifo_full[0];

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [OCC_W-1:0] count;
        logic [CNT_W-1:0] pop_count;
        logic             do_push;
        logic             do_pop;

        assign do_push = D_VALID && D_READY && (S == (i != 0));
        assign do_pop  = (count != '0) && sink_ready[i];

        always_ff @(posedge CLK) begin
            if (!RST && do_push) begin
                mem[wr_ptr] <= D;
            end
        end

        // Pointers are log2(DEPTH) wide, so incrementing past DEPTH-1 wraps to 0.
        always_ff @(posedge CLK) begin
            if (RST) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                pop_count <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    pop_count <= pop_count + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        assign fifo_full[i]  = (count == OCC_W'(DEPTH));
        assign head_valid[i] = (count != '0);
        assign head_data[i]  = head_valid[i] ? mem[rd_ptr] : '0;
        assign delivered[i]  = pop_count;
    end

    assign Y0       = head_data[0];
    assign Y1       = head_data[1];
    assign Y0_VALID = head_valid[0];
    assign Y1_VALID = head_valid[1];
    assign CNT0     = delivered[0];
    assign CNT1     = delivered[1];

endmodule

// File: tb/tb_demux_1x2_buf.sv
// Self-checking bench for demux_1x2_buf: a queue-based model tracks each output
// stream and is compared against the DUT on every falling edge.
module tb_demux_1x2_buf;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             CLK;
    logic             RST;
    logic [WIDTH-1:0] D;
    logic             D_VALID;
    logic             D_READY;
    logic             S;
    logic [WIDTH-1:0] Y0;
    logic             Y0_VALID;
    logic             Y0_READY;
    logic [WIDTH-1:0] Y1;
    logic             Y1_VALID;
    logic             Y1_READY;
    logic [CNT_W-1:0] CNT0;
    logic [CNT_W-1:0] CNT1;

    demux_1x2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .D(D), .D_VALID(D_VALID), .D_READY(D_READY), .S(S),
        .Y0(Y0), .Y0_VALID(Y0_VALID), .Y0_READY(Y0_READY),
        .Y1(Y1), .Y1_VALID(Y1_VALID), .Y1_READY(Y1_READY),
        .CNT0(CNT0), .CNT1(CNT1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int check_count = 0;
    int pass_count  = 0;
    bit check_en    = 1'b0;

    // Reference model: one queue per output plus delivered-beat counters.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int del0 = 0;
    int del1 = 0;
    bit m_accept, m_pop0, m_pop1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        else
            pass_count++;
    endtask

    task automatic applyStimulus(input logic rst, input logic dv, input logic [WIDTH-1:0] d,
                                 input logic s, input logic y0r, input logic y1r);
        RST      = rst;
        D_VALID  = dv;
        D        = d;
        S        = s;
        Y0_READY = y0r;
        Y1_READY = y1r;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            q0.delete();
            q1.delete();
            del0 = 0;
            del1 = 0;
        end else begin
            m_accept = D_VALID && (S ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
            m_pop0   = (q0.size() != 0) && Y0_READY;
            m_pop1   = (q1.size() != 0) && Y1_READY;
            if (m_pop0) begin
                void'(q0.pop_front());
                del0 = (del0 + 1) % (1 << CNT_W);
            end
            if (m_pop1) begin
                void'(q1.pop_front());
                del1 = (del1 + 1) % (1 << CNT_W);
            end
            if (m_accept) begin
                if (S) q1.push_back(D);
                else   q0.push_back(D);
            end
        end
    end

    // Every falling edge the DUT must agree with the model on all outputs.
    always @(negedge CLK) begin
        if (check_en) begin
            checkOutput("y0_valid", 32'(Y0_VALID), 32'(q0.size() != 0));
            checkOutput("y1_valid", 32'(Y1_VALID), 32'(q1.size() != 0));
            checkOutput("y0_data",  32'(Y0), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
            checkOutput("y1_data",  32'(Y1), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
            checkOutput("cnt0",     32'(CNT0), 32'(del0));
            checkOutput("cnt1",     32'(CNT1), 32'(del1));
            checkOutput("d_ready",  32'(D_READY),
                        32'(S ? (q1.size() < DEPTH) : (q0.size() < DEPTH)));
        end
    end

    initial begin
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);

        // Reset held two cycles with a beat offered; nothing may be stored.
        tick();
        check_en = 1'b1;
        tick();
        checkOutput("rst_y0_valid", 32'(Y0_VALID), 32'd0);
        checkOutput("rst_y1_valid", 32'(Y1_VALID), 32'd0);
        checkOutput("rst_y0", 32'(Y0), 32'd0);
        checkOutput("rst_cnt0", 32'(CNT0), 32'd0);
        checkOutput("rst_cnt1", 32'(CNT1), 32'd0);
        checkOutput("rst_d_ready", 32'(D_READY), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("rst_no_beat", 32'({Y1_VALID, Y0_VALID}), 32'd0);

        // Routing: one beat to each output.
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("route_y0", 32'({Y0_VALID, Y0}), 32'h1A5);
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("route_y1", 32'({Y1_VALID, Y1}), 32'h13C);
        checkOutput("route_cnt0", 32'(CNT0), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("route_cnt1", 32'(CNT1), 32'd1);

        // Backpressure: output 0 stalled until its FIFO fills.
        applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("full_d_ready", 32'(D_READY), 32'd0);
        tick();
        checkOutput("full_hold", 32'({Y0_VALID, Y0}), 32'h101);
        applyStimulus(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("drain_cnt0", 32'(CNT0), 32'd4);
        checkOutput("drain_empty", 32'(Y0_VALID), 32'd0);

        // Independence: FIFO0 parked full while output 1 streams.
        applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("indep_cnt1", 32'(CNT1), 32'd9);
        checkOutput("indep_y0", 32'({Y0_VALID, Y0}), 32'h1AA);

        // Simultaneous push and pop on FIFO1; the counter wraps at 16.
        applyStimulus(1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h41 + i), 1'b1, 1'b0, 1'b1);
            tick();
        end
        checkOutput("pp_y1", 32'({Y1_VALID, Y1}), 32'h150);
        checkOutput("pp_cnt1", 32'(CNT1), 32'd9);

        // Reset with both FIFOs holding two beats.
        applyStimulus(1'b0, 1'b1, 8'h51, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("midrst_valid", 32'({Y1_VALID, Y0_VALID}), 32'd0);
        checkOutput("midrst_cnt", 32'({CNT1, CNT0}), 32'd0);

        // Seventeen pops on output 0 wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("wrap_cnt0", 32'(CNT0), 32'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(39) == 0), 1'($urandom_range(1)), 8'($urandom),
                          1'($urandom_range(1)), 1'($urandom_range(3) != 0),
                          1'($urandom_range(1)));
            tick();
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
